// File: rtl/fpu_add_arbiter.sv
// fpu_add_arbiter: shares one combinational FP adder among NUM_REQ requesters (IDLE -> EXEC -> RESP).
// Define FPU_ADD_ARB_RR_EN for round-robin arbitration; otherwise fixed priority, lowest index wins.
module fpu_add_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int FLOAT_WIDTH = 16,
    parameter int RM_WIDTH    = 3    // width of fpu_rounding_mode_t
) (
    input  logic                           CLK,
    input  logic                           nRST,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*FLOAT_WIDTH-1:0] req_float1,
    input  logic [NUM_REQ*FLOAT_WIDTH-1:0] req_float2,
    input  logic [NUM_REQ*RM_WIDTH-1:0]    req_rounding_mode,
    output logic [FLOAT_WIDTH-1:0]         add_float1,
    output logic [FLOAT_WIDTH-1:0]         add_float2,
    output logic [RM_WIDTH-1:0]            add_rounding_mode,
    input  logic [FLOAT_WIDTH-1:0]         add_sum,
    output logic [NUM_REQ-1:0]             resp_valid,
    input  logic [NUM_REQ-1:0]             resp_ready,
    output logic [FLOAT_WIDTH-1:0]         resp_sum,
    output logic                           busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                 state_q;
    logic [IDX_W-1:0]       owner_q;
    logic [FLOAT_WIDTH-1:0] op1_q;
    logic [FLOAT_WIDTH-1:0] op2_q;
    logic [RM_WIDTH-1:0]    rm_q;
    logic [FLOAT_WIDTH-1:0] sum_q;
    logic [NUM_REQ-1:0]     resp_valid_q;
    logic                   busy_q;

    logic                   win_found;
    logic [IDX_W-1:0]       win_idx;
    logic [FLOAT_WIDTH-1:0] sel_op1;
    logic [FLOAT_WIDTH-1:0] sel_op2;
    logic [RM_WIDTH-1:0]    sel_rm;

`ifdef FPU_ADD_ARB_RR_EN
    logic [IDX_W-1:0]       ptr_q;
    logic [IDX_W-1:0]       cand;
`endif

    // Winner selection; the search starts just after the last winner in round-robin mode.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
`ifdef FPU_ADD_ARB_RR_EN
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!win_found && (cand == IDX_W'(i)) && req_valid[i]) begin
                    win_found = 1'b1;
                    win_idx   = cand;
                end
            end
        end
`else
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(i);
            end
        end
`endif
    end

    always_comb begin
        sel_op1 = '0;
        sel_op2 = '0;
        sel_rm  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx == IDX_W'(i)) begin
                sel_op1 = req_float1[i*FLOAT_WIDTH +: FLOAT_WIDTH];
                sel_op2 = req_float2[i*FLOAT_WIDTH +: FLOAT_WIDTH];
                sel_rm  = req_rounding_mode[i*RM_WIDTH +: RM_WIDTH];
            end
        end
    end

    // Grant is combinational from req_valid and never looks at resp_ready.
    always_comb begin
        req_ready = '0;
        if (nRST && (state_q == IDLE) && win_found) begin
            req_ready[win_idx] = 1'b1;
        end
    end

    assign add_float1        = op1_q;
    assign add_float2        = op2_q;
    assign add_rounding_mode = rm_q;
    assign resp_sum          = sum_q;
    assign resp_valid        = nRST ? resp_valid_q : '0;
    assign busy              = nRST & busy_q;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            op1_q        <= '0;
            op2_q        <= '0;
            rm_q         <= '0;
            sum_q        <= '0;
            resp_valid_q <= '0;
            busy_q       <= 1'b0;
`ifdef FPU_ADD_ARB_RR_EN
            ptr_q        <= IDX_W'(NUM_REQ - 1);
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (win_found) begin
                        owner_q <= win_idx;
                        op1_q   <= sel_op1;
                        op2_q   <= sel_op2;
                        rm_q    <= sel_rm;
                        busy_q  <= 1'b1;
                        state_q <= EXEC;
`ifdef FPU_ADD_ARB_RR_EN
                        ptr_q   <= win_idx;
`endif
                    end
                end
                EXEC: begin
                    sum_q        <= add_sum;
                    resp_valid_q <= NUM_REQ'(1) << owner_q;
                    state_q      <= RESP;
                end
                RESP: begin
                    if (resp_ready[owner_q]) begin
                        resp_valid_q <= '0;
                        busy_q       <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    resp_valid_q <= '0;
                    busy_q       <= 1'b0;
                    state_q      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_add_arbiter.sv
// tb_fpu_add_arbiter: scoreboard bench for fpu_add_arbiter with a behavioural stand-in adder.
// Grant-order expectations follow FPU_ADD_ARB_RR_EN when it is defined.
`timescale 1ns/1ps
module tb_fpu_add_arbiter;

    localparam int N  = 4;
    localparam int FW = 16;
    localparam int RW = 3;

    logic            CLK = 1'b0;
    logic            nRST;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*FW-1:0] req_float1;
    logic [N*FW-1:0] req_float2;
    logic [N*RW-1:0] req_rounding_mode;
    logic [FW-1:0]   add_float1;
    logic [FW-1:0]   add_float2;
    logic [RW-1:0]   add_rounding_mode;
    logic [FW-1:0]   add_sum;
    logic [N-1:0]    resp_valid;
    logic [N-1:0]    resp_ready;
    logic [FW-1:0]   resp_sum;
    logic            busy;

    logic [FW-1:0] sb[$];
    int            grant_log[$];
    int            n_cmp = 0;
    int            n_err = 0;

    int ph  = 0;    // reference FSM: 0 idle, 1 exec, 2 resp
    int own = 0;
    int ptr = N - 1;

    fpu_add_arbiter #(.NUM_REQ(N), .FLOAT_WIDTH(FW), .RM_WIDTH(RW)) dut (
        .CLK(CLK), .nRST(nRST),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_float1(req_float1), .req_float2(req_float2),
        .req_rounding_mode(req_rounding_mode),
        .add_float1(add_float1), .add_float2(add_float2),
        .add_rounding_mode(add_rounding_mode), .add_sum(add_sum),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_sum(resp_sum), .busy(busy)
    );

    always #5 CLK = ~CLK;

    // Stand-in adder: real half-float results for the named vectors, a non-commutative mix otherwise.
    function automatic logic [FW-1:0] fake_add(input logic [FW-1:0] a, input logic [FW-1:0] b,
                                               input logic [RW-1:0] rm);
        if (rm == 3'd0) begin
            if (a == 16'h3C00 && b == 16'h3C00) return 16'h4000;
            if (a == 16'h3C00 && b == 16'hBC00) return 16'h0000;
            if (a == 16'h7C00 && b == 16'hFC00) return 16'h7E00;
        end
        return a + (b << 1) + {5'd0, rm, 8'd0};
    endfunction

    always_comb add_sum = fake_add(add_float1, add_float2, add_rounding_mode);

    function automatic int arb(input logic [N-1:0] v, input int p);
`ifdef FPU_ADD_ARB_RR_EN
        for (int k = 1; k <= N; k++) if (v[(p + k) % N]) return (p + k) % N;
`else
        for (int i = 0; i < N; i++) if (v[i]) return i;
`endif
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model and scoreboard, sampled mid-cycle.
    always @(negedge CLK) begin
        int w;
        logic [31:0] er;
        #2;
        if (nRST !== 1'b1) begin
            chk("rst_req_ready", 32'(req_ready), 32'd0);
            chk("rst_resp_valid", 32'(resp_valid), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            ph  = 0;
            ptr = N - 1;
            sb.delete();
        end else begin
            w  = (ph == 0) ? arb(req_valid, ptr) : -1;
            er = (w >= 0) ? (32'd1 << w) : 32'd0;
            chk("req_ready", 32'(req_ready), er);
            chk("busy", 32'(busy), (ph != 0) ? 32'd1 : 32'd0);
            chk("resp_valid", 32'(resp_valid), (ph == 2) ? (32'd1 << own) : 32'd0);
            case (ph)
                0: if (w >= 0) begin
                    own = w;
                    ptr = w;
                    grant_log.push_back(w);
                    sb.push_back(fake_add(req_float1[w*FW +: FW], req_float2[w*FW +: FW],
                                          req_rounding_mode[w*RW +: RW]));
                    ph = 1;
                end
                1: ph = 2;
                default: begin
                    if (sb.size() > 0) chk("resp_sum", 32'(resp_sum), 32'(sb[0]));
                    if (resp_ready[own]) begin
                        void'(sb.pop_front());
                        ph = 0;
                    end
                end
            endcase
        end
    end

    task automatic set_req(input int i, input logic [FW-1:0] a, input logic [FW-1:0] b,
                           input logic [RW-1:0] rm);
        req_float1[i*FW +: FW]        = a;
        req_float2[i*FW +: FW]        = b;
        req_rounding_mode[i*RW +: RW] = rm;
        req_valid[i]                  = 1'b1;
    endtask

    // Returns on the negedge after acceptance, with operands scrambled to prove they were captured.
    task automatic issue(input int i, input logic [FW-1:0] a, input logic [FW-1:0] b,
                         input logic [RW-1:0] rm);
        @(negedge CLK);
        set_req(i, a, b, rm);
        for (int c = 0; c < 50; c++) begin
            #1;
            if (req_ready[i]) begin
                @(negedge CLK);
                req_valid[i]           = 1'b0;
                req_float1[i*FW +: FW] = 16'($urandom);
                req_float2[i*FW +: FW] = 16'($urandom);
                return;
            end
            @(negedge CLK);
        end
        chk("accept_timeout", 32'(req_ready), 32'd1 << i);
        req_valid[i] = 1'b0;
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 100; c++) begin
            @(negedge CLK);
            #3;
            if (busy === 1'b0 && sb.size() == 0) return;
        end
        chk("drain_timeout", 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_ord[5];
        logic [N-1:0] acc;

        nRST              = 1'b0;
        req_valid         = '0;
        req_float1        = '0;
        req_float2        = '0;
        req_rounding_mode = '0;
        resp_ready        = '1;
        repeat (3) @(negedge CLK);
        #3;
        chk("rst_resp_sum", 32'(resp_sum), 32'd0);
        chk("rst_add_float1", 32'(add_float1), 32'd0);
        @(negedge CLK);
        nRST = 1'b1;

        // 1.0 + 1.0 from requester 0, response two cycles after the grant.
        issue(0, 16'h3C00, 16'h3C00, 3'd0);
        @(negedge CLK);
        #3;
        chk("r0_resp_valid", 32'(resp_valid), 32'h1);
        chk("r0_resp_sum", 32'(resp_sum), 32'h4000);
        wait_idle();

        // 1.0 + -1.0 from requester 2 with the result held off.
        resp_ready = '0;
        issue(2, 16'h3C00, 16'hBC00, 3'd0);
        @(negedge CLK);
        for (int c = 0; c < 5; c++) begin
            #3;
            chk("hold_resp_valid", 32'(resp_valid), 32'h4);
            chk("hold_resp_sum", 32'(resp_sum), 32'h0000);
            chk("hold_busy", 32'(busy), 32'd1);
            @(negedge CLK);
        end
        resp_ready = 4'b1011;
        for (int c = 0; c < 2; c++) begin
            #3;
            chk("nonowner_resp_valid", 32'(resp_valid), 32'h4);
            chk("nonowner_busy", 32'(busy), 32'd1);
            @(negedge CLK);
        end
        resp_ready = '1;
        wait_idle();

        // +inf + -inf from requester 1.
        issue(1, 16'h7C00, 16'hFC00, 3'd0);
        @(negedge CLK);
        #3;
        chk("nan_resp_valid", 32'(resp_valid), 32'h2);
        chk("nan_resp_sum", 32'(resp_sum), 32'h7E00);
        wait_idle();

        for (int t = 0; t < 6; t++) begin
            issue(int'($urandom_range(0, N - 1)), 16'($urandom), 16'($urandom),
                  3'($urandom_range(0, 7)));
            wait_idle();
        end

        // Two simultaneous requesters.
        @(negedge CLK);
        set_req(3, 16'h1111, 16'h0202, 3'd3);
        set_req(1, 16'h2345, 16'h0033, 3'd1);
        for (int c = 0; c < 40; c++) begin
            #1;
            acc = req_ready;
            @(negedge CLK);
            req_valid = req_valid & ~acc;
            if (req_valid == '0) break;
        end
        chk("pair_pending", 32'(req_valid), 32'd0);
        req_valid = '0;
        wait_idle();

        // All requesters valid continuously, starting from reset.
        nRST = 1'b0;
        @(negedge CLK);
        nRST = 1'b1;
        grant_log.delete();
        for (int i = 0; i < N; i++) set_req(i, 16'(16'h1000 * (i + 1)), 16'h0100, 3'(i));
        repeat (16) @(negedge CLK);
        req_valid = '0;
        wait_idle();
`ifdef FPU_ADD_ARB_RR_EN
        exp_ord = '{0, 1, 2, 3, 0};
`else
        exp_ord = '{0, 0, 0, 0, 0};
`endif
        for (int i = 0; i < 5; i++) begin
            if (i < grant_log.size()) chk("grant_order", 32'(grant_log[i]), 32'(exp_ord[i]));
            else chk("grant_count", 32'(grant_log.size()), 32'(i + 1));
        end

        // Reset while the operation is in EXEC, with another request pending.
        issue(3, 16'h1234, 16'h0042, 3'd2);
        nRST = 1'b0;
        set_req(1, 16'h2222, 16'h0101, 3'd1);
        #3;
        chk("rstx_resp_valid", 32'(resp_valid), 32'd0);
        chk("rstx_req_ready", 32'(req_ready), 32'd0);
        @(negedge CLK);
        nRST = 1'b1;
        #3;
        chk("rstx_resp_sum", 32'(resp_sum), 32'h0000);
        chk("rstx_after_valid", 32'(resp_valid), 32'd0);
        chk("rstx_grant", 32'(req_ready), 32'h2);
        @(negedge CLK);
        req_valid[1] = 1'b0;
        wait_idle();

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
